// File: rtl/test_44_pkg.sv
// test_44_pkg: shared constants and types for the test_44 moving-average filter.
//   DATA_W_DEF    - default sample/output width
//   TAPS_LOG2_DEF - default log2 of the averaging window
//   TAPS, SUM_W   - derived window length and full-precision sum width
//   sample_t, sum_t - sample and sum types at the default sizes
package test_44_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int TAPS_LOG2_DEF = 2;
  localparam int TAPS          = 2 ** TAPS_LOG2_DEF;
  localparam int SUM_W         = DATA_W_DEF + TAPS_LOG2_DEF;

  typedef logic [DATA_W_DEF-1:0] sample_t;
  typedef logic [SUM_W-1:0]      sum_t;

endpackage

// File: rtl/test_44_delay_line.sv
// test_44_delay_line: shift register of DEPTH samples with synchronous clear.
//   clk    - clock, rising edge
//   rst    - synchronous active-high clear of every entry
//   i_data - sample shifted into entry 0 each cycle
//   o_taps - all entries, flattened; entry k at [k*DATA_W +: DATA_W],
//            entry 0 is the newest past sample
// DEPTH must be at least 1.
module test_44_delay_line
  import test_44_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = TAPS - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       i_data,
  output logic [DEPTH*DATA_W-1:0] o_taps
);

  logic [DEPTH*DATA_W-1:0] taps_q;
  logic [DEPTH*DATA_W-1:0] taps_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb begin
        taps_d = i_data;
      end
    end else begin : g_multi
      // Oldest entry falls off the top; newest enters at entry 0.
      always_comb begin
        taps_d = {taps_q[(DEPTH-1)*DATA_W-1:0], i_data};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign o_taps = taps_q;

endmodule

// File: rtl/test_44.sv
// test_44: streaming moving-average filter over 2**TAPS_LOG2 unsigned samples.
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset; clears history and output
//   i_data - unsigned sample, taken every cycle while rst is low
//   o_y    - registered windowed average (1-cycle latency)
// Build option: TEST_44_ROUND_EN selects round-half-up instead of truncation.
// History starts at zero after reset, so the first outputs ramp up.
module test_44
  import test_44_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAPS_LOG2 = TAPS_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_y
);

  localparam int N_TAPS = 2 ** TAPS_LOG2;
  localparam int S_W    = DATA_W + TAPS_LOG2;
  localparam int DEPTH  = N_TAPS - 1;

  logic [DEPTH*DATA_W-1:0] taps;
  logic [S_W-1:0]          sum;
  logic [DATA_W-1:0]       y_d;
  logic [DATA_W-1:0]       y_q;

  test_44_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_delay_line (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .o_taps (taps)
  );

  // S_W bits hold N_TAPS full-scale samples without overflow.
  always_comb begin
    sum = S_W'(i_data);
    for (int k = 0; k < DEPTH; k++) begin
      sum = sum + S_W'(taps[k*DATA_W +: DATA_W]);
    end
  end

`ifdef TEST_44_ROUND_EN
  // One extra bit keeps the half-LSB addition from wrapping; the shifted
  // result still never exceeds 2**DATA_W-1.
  localparam logic [S_W:0] RND = (S_W+1)'(1) << (TAPS_LOG2 - 1);
  logic [S_W:0] sum_rnd;

  always_comb begin
    sum_rnd = {1'b0, sum} + RND;
    y_d     = DATA_W'(sum_rnd >> TAPS_LOG2);
  end
`else
  always_comb begin
    y_d = DATA_W'(sum >> TAPS_LOG2);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign o_y = y_q;

endmodule

// File: tb/tb_test_44.sv
module tb_test_44;

  logic       clk;
  logic       rst;
  logic [7:0] i_data;
  logic [7:0] o_y;

  int n_checks = 0;
  int n_errors = 0;

  test_44 dut (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .o_y    (o_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; output sampled 1 time unit after rising edge.
  task automatic drive(input logic r, input logic [7:0] d);
    @(negedge clk);
    rst    = r;
    i_data = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] step_exp [5]  = '{8'd25, 8'd50, 8'd75, 8'd100, 8'd100};
`ifdef TEST_44_ROUND_EN
  logic [7:0] full_exp [5]  = '{8'd64, 8'd128, 8'd191, 8'd255, 8'd255};
  logic [7:0] alt_exp       = 8'd128;
`else
  logic [7:0] full_exp [5]  = '{8'd63, 8'd127, 8'd191, 8'd255, 8'd255};
  logic [7:0] alt_exp       = 8'd127;
`endif
  logic [7:0] resume_exp [4] = '{8'd50, 8'd100, 8'd150, 8'd200};

  logic [7:0] h [3];
  logic [9:0] s;
  logic [7:0] x;
  logic [7:0] ref_y;

  initial begin
    rst    = 1'b1;
    i_data = 8'd0;

    // Reset held for two edges with random data.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)));
      chk("reset", o_y, 8'd0);
    end

    // Step response.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'd100);
      chk($sformatf("step[%0d]", i), o_y, step_exp[i]);
    end

    // Full scale from reset.
    drive(1'b1, 8'd0);
    chk("reset_before_full", o_y, 8'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'd255);
      chk($sformatf("full[%0d]", i), o_y, full_exp[i]);
    end

    // Alternating 0/255; steady state from the fourth sample on.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i % 2 == 0) ? 8'd0 : 8'd255);
      if (i >= 3) chk($sformatf("alt[%0d]", i), o_y, alt_exp);
    end

    // Reset mid-stream in steady 200.
    for (int i = 0; i < 5; i++) drive(1'b0, 8'd200);
    chk("steady200", o_y, 8'd200);
    drive(1'b1, 8'd200);
    chk("mid_reset", o_y, 8'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd200);
      chk($sformatf("resume[%0d]", i), o_y, resume_exp[i]);
    end

    // Random stimulus against a zero-initialised reference window.
    drive(1'b1, 8'd0);
    chk("reset_before_rand", o_y, 8'd0);
    for (int k = 0; k < 3; k++) h[k] = 8'd0;
    for (int i = 0; i < 10000; i++) begin
      x = 8'($urandom_range(0, 255));
      s = 10'(x) + 10'(h[0]) + 10'(h[1]) + 10'(h[2]);
`ifdef TEST_44_ROUND_EN
      ref_y = 8'((s + 10'd2) >> 2);
`else
      ref_y = 8'(s >> 2);
`endif
      h[2] = h[1];
      h[1] = h[0];
      h[0] = x;
      drive(1'b0, x);
      chk("random", o_y, ref_y);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
